// File: rtl/cla_add_sequencer_pkg.sv
// Shared types and widths for the carry-lookahead add/sub sequencer.
// Operands are captured as one op_t and walked through the 32-bit slice in two passes.
package cla_add_sequencer_pkg;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned SLICE = 32;
  localparam int unsigned NREQ  = 2;

  typedef enum logic [1:0] {
    IDLE,
    LO,
    HI,
    RESP
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            sub;
    logic            word;
    logic            id;
  } op_t;

endpackage

// File: rtl/cla_add_sequencer_if.sv
// Request/response bundle between the two stage-3 requesters and the add sequencer.
interface cla_add_sequencer_if;
  import cla_add_sequencer_pkg::*;

  logic [NREQ-1:0]           req_valid;
  logic [NREQ-1:0]           req_ready;
  logic [NREQ-1:0][XLEN-1:0] req_a;
  logic [NREQ-1:0][XLEN-1:0] req_b;
  logic [NREQ-1:0]           req_sub;
  logic [NREQ-1:0]           req_word;
  logic                      resp_valid;
  logic                      resp_ready;
  logic                      resp_id;
  logic [XLEN-1:0]           resp_data;
  logic                      resp_carry;

  modport master (
    output req_valid, req_a, req_b, req_sub, req_word, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_data, resp_carry
  );

  modport slave (
    input  req_valid, req_a, req_b, req_sub, req_word, resp_ready,
    output req_ready, resp_valid, resp_id, resp_data, resp_carry
  );

endinterface

// File: rtl/cla_slice.sv
// Combinational W-bit carry-lookahead adder: 4-bit lookahead groups chained by group generate/propagate.
module cla_slice #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  localparam int unsigned GROUPS = W / 4;

  logic [W-1:0] g;
  logic [W-1:0] p;
  logic [W:0]   c;
  logic         grp_g;
  logic         grp_p;

  always_comb begin
    g     = a & b;
    p     = a ^ b;
    c     = '0;
    grp_g = 1'b0;
    grp_p = 1'b0;
    c[0]  = cin;
    for (int k = 0; k < int'(GROUPS); k++) begin
      c[4*k+1] = g[4*k] | (p[4*k] & c[4*k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & c[4*k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
      // Group terms let the carry skip each 4-bit block directly
      grp_g = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      grp_p = p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k];
      c[4*k+4] = grp_g | (grp_p & c[4*k]);
    end
    sum  = p ^ c[W-1:0];
    cout = c[W];
  end

endmodule

// File: rtl/cla_add_sequencer.sv
// Round-robin shares one 32-bit CLA slice between two requesters for 64-bit and word add/sub.
// A 64-bit op takes LO then HI passes with a registered inter-slice carry; word ops skip HI.
module cla_add_sequencer
  import cla_add_sequencer_pkg::*;
(
  input logic               clk,
  input logic               rst_n,
  cla_add_sequencer_if.slave bus
);

  state_e            state_q;
  state_e            state_d;
  op_t               op_q;
  logic              last_grant_q;
  logic [SLICE-1:0]  sum_lo_q;
  logic              carry_lo_q;
  logic              resp_valid_q;
  logic              resp_id_q;
  logic              resp_carry_q;
  logic [XLEN-1:0]   resp_data_q;

  logic [NREQ-1:0]   grant_c;
  logic              grant_id_c;
  logic              accept_c;
  logic [XLEN-1:0]   b_eff_c;
  logic [SLICE-1:0]  slice_a_c;
  logic [SLICE-1:0]  slice_b_c;
  logic              slice_cin_c;
  logic [SLICE-1:0]  slice_sum_c;
  logic              slice_cout_c;

  // Round-robin arbiter; grant is held off entirely while in reset
  always_comb begin
    grant_c = '0;
    if (rst_n && (state_q == IDLE)) begin
      if (&bus.req_valid) begin
        grant_c = last_grant_q ? 2'b01 : 2'b10;
      end else begin
        grant_c = bus.req_valid;
      end
    end
  end

  assign grant_id_c    = grant_c[1];
  assign accept_c      = |grant_c;
  assign bus.req_ready = grant_c;

  // Slice operand mux: low halves with the op carry-in, then high halves with the saved carry
  assign b_eff_c = op_q.sub ? ~op_q.b : op_q.b;

  always_comb begin
    slice_a_c   = op_q.a[SLICE-1:0];
    slice_b_c   = b_eff_c[SLICE-1:0];
    slice_cin_c = op_q.sub;
    if (state_q == HI) begin
      slice_a_c   = op_q.a[XLEN-1:SLICE];
      slice_b_c   = b_eff_c[XLEN-1:SLICE];
      slice_cin_c = carry_lo_q;
    end
  end

  cla_slice #(
    .W (SLICE)
  ) u_slice (
    .a    (slice_a_c),
    .b    (slice_b_c),
    .cin  (slice_cin_c),
    .sum  (slice_sum_c),
    .cout (slice_cout_c)
  );

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_c) state_d = LO;
      LO:      state_d = op_q.word ? RESP : HI;
      HI:      state_d = RESP;
      RESP:    if (bus.resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture, slice results and the registered response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q         <= '0;
      last_grant_q <= 1'b1;
      sum_lo_q     <= '0;
      carry_lo_q   <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_carry_q <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_c) begin
            op_q <= '{a:    bus.req_a[grant_id_c],
                      b:    bus.req_b[grant_id_c],
                      sub:  bus.req_sub[grant_id_c],
                      word: bus.req_word[grant_id_c],
                      id:   grant_id_c};
            last_grant_q <= grant_id_c;
          end
        end
        LO: begin
          sum_lo_q   <= slice_sum_c;
          carry_lo_q <= slice_cout_c;
          if (op_q.word) begin
            resp_valid_q <= 1'b1;
            resp_id_q    <= op_q.id;
            resp_carry_q <= slice_cout_c;
            resp_data_q  <= {{(XLEN-SLICE){slice_sum_c[SLICE-1]}}, slice_sum_c};
          end
        end
        HI: begin
          resp_valid_q <= 1'b1;
          resp_id_q    <= op_q.id;
          resp_carry_q <= slice_cout_c;
          resp_data_q  <= {slice_sum_c, sum_lo_q};
        end
        RESP: begin
          if (bus.resp_ready) resp_valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_id    = resp_id_q;
  assign bus.resp_carry = resp_carry_q;
  assign bus.resp_data  = resp_data_q;

endmodule

// File: tb/tb_cla_add_sequencer.sv
// Directed bench for cla_add_sequencer: vector table plus contention, backpressure and reset sequences.
module tb_cla_add_sequencer;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  cla_add_sequencer_if bus ();

  cla_add_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        id;
    logic [63:0] a;
    logic [63:0] b;
    logic        sub;
    logic        word;
    logic [63:0] exp_data;
    logic        exp_carry;
  } vec_t;

  vec_t vecs[11];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish before 200000");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v);
    int n;
    @(negedge clk);
    bus.req_a[v.id]    = v.a;
    bus.req_b[v.id]    = v.b;
    bus.req_sub[v.id]  = v.sub;
    bus.req_word[v.id] = v.word;
    bus.req_valid      = v.id ? 2'b10 : 2'b01;
    #1 chk("vec_req_ready", 64'(bus.req_ready), v.id ? 64'h2 : 64'h1);
    @(posedge clk);
    #1 bus.req_valid = 2'b00;
    for (n = 1; n <= 8; n++) begin
      @(posedge clk);
      #1;
      if (bus.resp_valid) break;
    end
    // Edges after the accepting edge: 2 for a 64-bit op, 1 for a word op
    chk("vec_latency", 64'(n), v.word ? 64'd1 : 64'd2);
    chk("vec_data", bus.resp_data, v.exp_data);
    chk("vec_carry", 64'(bus.resp_carry), 64'(v.exp_carry));
    chk("vec_id", 64'(bus.resp_id), 64'(v.id));
    @(posedge clk);
    #1 chk("vec_resp_drop", 64'(bus.resp_valid), 64'd0);
  endtask

  initial begin
    int n;
    int grants;
    int resps;
    logic exp_ids[$];
    logic eid;

    n_cmp = 0;
    n_err = 0;

    vecs[0]  = '{1'b0, 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0000_0001_0000_0000, 1'b0};
    vecs[1]  = '{1'b1, 64'h0, 64'h1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    vecs[2]  = '{1'b1, 64'h5, 64'h3, 1'b1, 1'b0, 64'h2, 1'b1};
    vecs[3]  = '{1'b0, 64'h1234_5678_7FFF_FFFF, 64'h1, 1'b0, 1'b1, 64'hFFFF_FFFF_8000_0000, 1'b0};
    vecs[4]  = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1};
    vecs[5]  = '{1'b1, 64'hAAAA_AAAA_0000_0005, 64'hBBBB_BBBB_0000_0007, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0};
    vecs[6]  = '{1'b0, 64'hFFFF_FFFF_0000_0010, 64'h0000_0001_0000_0003, 1'b1, 1'b1, 64'hD, 1'b1};
    vecs[7]  = '{1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0};
    vecs[8]  = '{1'b0, 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 1'b1, 64'h0, 1'b1};
    vecs[9]  = '{1'b1, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    vecs[10] = '{1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 64'h0, 1'b1};

    // Reset with both requesters asserting valid: no grant may leak out
    rst_n          = 1'b0;
    bus.req_valid  = 2'b11;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.req_sub    = '0;
    bus.req_word   = '0;
    bus.resp_ready = 1'b1;
    #12;
    chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_resp_data", bus.resp_data, 64'd0);
    chk("rst_resp_id", 64'(bus.resp_id), 64'd0);
    chk("rst_resp_carry", 64'(bus.resp_carry), 64'd0);
    @(negedge clk);
    bus.req_valid = 2'b00;
    rst_n         = 1'b1;

    foreach (vecs[i]) run_op(vecs[i]);

    // Backpressure: req0 result held while req1 waits
    @(negedge clk);
    bus.resp_ready  = 1'b0;
    bus.req_a[0]    = 64'd100;
    bus.req_b[0]    = 64'd23;
    bus.req_sub[0]  = 1'b0;
    bus.req_word[0] = 1'b0;
    bus.req_valid   = 2'b01;
    #1 chk("bp_req_ready", 64'(bus.req_ready), 64'h1);
    @(posedge clk);
    #1;
    bus.req_a[1]    = 64'd9;
    bus.req_b[1]    = 64'd1;
    bus.req_sub[1]  = 1'b1;
    bus.req_word[1] = 1'b0;
    bus.req_valid   = 2'b10;
    for (n = 0; n < 10; n++) begin
      @(negedge clk);
      #1;
      if (bus.resp_valid) break;
    end
    chk("bp_resp_seen", 64'(n < 10), 64'd1);
    for (int k = 0; k < 5; k++) begin
      chk("bp_hold_valid", 64'(bus.resp_valid), 64'd1);
      chk("bp_hold_data", bus.resp_data, 64'd123);
      chk("bp_hold_id", 64'(bus.resp_id), 64'd0);
      chk("bp_no_ready", 64'(bus.req_ready), 64'd0);
      @(negedge clk);
      #1;
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("bp_resp_done", 64'(bus.resp_valid), 64'd0);
    chk("bp_resume_ready", 64'(bus.req_ready), 64'h2);
    @(posedge clk);
    #1 bus.req_valid = 2'b00;
    for (n = 0; n < 10; n++) begin
      @(negedge clk);
      #1;
      if (bus.resp_valid) break;
    end
    chk("bp2_resp_seen", 64'(n < 10), 64'd1);
    chk("bp2_data", bus.resp_data, 64'd8);
    chk("bp2_carry", 64'(bus.resp_carry), 64'd1);
    chk("bp2_id", 64'(bus.resp_id), 64'd1);
    @(posedge clk);

    // Asynchronous reset while the HI pass is in progress
    @(negedge clk);
    bus.req_a[0]    = 64'h0000_0000_FFFF_FFFF;
    bus.req_b[0]    = 64'h1;
    bus.req_sub[0]  = 1'b0;
    bus.req_word[0] = 1'b0;
    bus.req_valid   = 2'b01;
    @(posedge clk);
    #1 bus.req_valid = 2'b00;
    @(posedge clk);
    #3;
    bus.req_valid = 2'b11;
    rst_n         = 1'b0;
    #1;
    chk("midrst_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("midrst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("midrst_resp_data", bus.resp_data, 64'd0);
    chk("midrst_resp_id", 64'(bus.resp_id), 64'd0);
    chk("midrst_resp_carry", 64'(bus.resp_carry), 64'd0);
    repeat (2) @(negedge clk);
    bus.req_valid = 2'b00;
    rst_n         = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1 chk("postrst_no_resp", 64'(bus.resp_valid), 64'd0);
    end

    // Contention: both held valid, grants must alternate starting with requester 0
    @(negedge clk);
    bus.req_a[0]    = 64'd10;
    bus.req_b[0]    = 64'd1;
    bus.req_sub[0]  = 1'b0;
    bus.req_word[0] = 1'b0;
    bus.req_a[1]    = 64'd20;
    bus.req_b[1]    = 64'd3;
    bus.req_sub[1]  = 1'b1;
    bus.req_word[1] = 1'b0;
    bus.req_valid   = 2'b11;
    grants = 0;
    resps  = 0;
    for (int cyc = 0; cyc < 60 && resps < 4; cyc++) begin
      #1;
      if (bus.req_ready != 2'b00) begin
        chk("rr_order", 64'(bus.req_ready), (grants % 2 == 1) ? 64'h2 : 64'h1);
        exp_ids.push_back(grants % 2 == 1);
        grants++;
      end
      if (bus.resp_valid) begin
        eid = (exp_ids.size() > 0) ? exp_ids.pop_front() : 1'bx;
        chk("rr_resp_id", 64'(bus.resp_id), 64'(eid));
        chk("rr_resp_data", bus.resp_data, eid ? 64'd17 : 64'd11);
        resps++;
      end
      @(negedge clk);
    end
    chk("rr_grants", 64'(grants), 64'd4);
    chk("rr_resps", 64'(resps), 64'd4);
    bus.req_valid = 2'b00;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
